// File: rtl/battle_pkg.sv
// Shared battle-screen definitions: state codes seen by the phase/sprite
// modules and the controller orientation encodings from the input decoder.
package battle_pkg;

  typedef enum logic [3:0] {
    ST_MENU   = 4'b0000,
    ST_PLAYER = 4'b0001,
    ST_ENEMY  = 4'b0010,
    ST_CHK_P  = 4'b0011,
    ST_WIN    = 4'b0100,
    ST_LOSE   = 4'b0101,
    ST_CHK_E  = 4'b0110,
    ST_IDLE   = 4'b1010
  } state_e;

  localparam logic [1:0] ROT_UP    = 2'b00;
  localparam logic [1:0] ROT_SWIPE = 2'b01;

  localparam logic [7:0] ROUND_MAX = 8'hFF;

  // True while a phase module owns the screen and a finished handshake is due.
  function automatic logic is_phase(state_e s);
    return (s == ST_PLAYER) || (s == ST_ENEMY);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase watchdog: counts cycles spent in a phase and flags the last
// allowed cycle so the sequencer can force the phase to end.
module phase_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 650_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Count phase cycles; hold at the limit so the flag cannot wrap away.
  always_ff @(posedge clk) begin
    if (rst || clear)
      r_cnt <= '0;
    else if (enable && (r_cnt != LAST))
      r_cnt <= r_cnt + 1'b1;
  end

  assign expired = enable && (r_cnt == LAST);

endmodule

// File: rtl/battle_sequencer.sv
// Battle-screen turn controller. Walks IDLE/MENU/PLAYER/ENEMY/CHK/WIN/LOSE,
// waits on each phase's finished handshake, samples health in the one-cycle
// CHK states and counts completed rounds.
// Build option: BATTLE_SEQ_TIMEOUT_EN adds a per-phase watchdog that forces a
// phase exit after TIMEOUT_CYCLES cycles; without it phases wait forever.
module battle_sequencer
  import battle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 650_000_000,
  parameter int          HP_W           = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic [1:0]      rotate_in,
  input  logic            player_finished_in,
  input  logic            enemy_finished_in,
  input  logic [HP_W-1:0] enemy_hp_in,
  input  logic [HP_W-1:0] player_hp_in,
  output logic [3:0]      state_out,
  output logic            phase_start_out,
  output logic [7:0]      round_out,
  output logic            timeout_out,
  output logic            game_over_out
);

  state_e r_state;
  logic   r_armed;
  logic   r_phase_start;
  logic   r_timeout;
  logic   r_game_over;
  logic [7:0] r_round;
  logic   w_expired;

`ifdef BATTLE_SEQ_TIMEOUT_EN
  logic w_in_phase;
  assign w_in_phase = is_phase(r_state);

  // Counter restarts whenever we are outside a phase, so each entry starts at 0.
  phase_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!w_in_phase),
    .enable  (w_in_phase),
    .expired (w_expired)
  );
`else
  // TIMEOUT_CYCLES only sizes the watchdog, which this build leaves out.
  if (TIMEOUT_CYCLES > 0) begin : g_no_wd
    assign w_expired = 1'b0;
  end else begin : g_no_wd_zero
    assign w_expired = 1'b0;
  end
`endif

  // Game FSM; every output is registered together with the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_armed       <= 1'b0;
      r_phase_start <= 1'b0;
      r_timeout     <= 1'b0;
      r_game_over   <= 1'b0;
      r_round       <= '0;
    end else begin
      r_phase_start <= 1'b0;
      r_timeout     <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            r_state <= ST_MENU;
            r_round <= '0;
          end
        end
        ST_MENU: begin
          // Swipe = UP then SWIPE; a bare SWIPE is ignored.
          if ((rotate_in == ROT_SWIPE) && r_armed) begin
            r_state       <= ST_PLAYER;
            r_armed       <= 1'b0;
            r_phase_start <= 1'b1;
          end else if (rotate_in == ROT_UP) begin
            r_armed <= 1'b1;
          end
        end
        ST_PLAYER: begin
          // Finished wins over a simultaneous expiry: no timeout pulse then.
          if (player_finished_in) begin
            r_state <= ST_CHK_P;
          end else if (w_expired) begin
            r_state   <= ST_CHK_P;
            r_timeout <= 1'b1;
          end
        end
        ST_ENEMY: begin
          if (enemy_finished_in) begin
            r_state <= ST_CHK_E;
          end else if (w_expired) begin
            r_state   <= ST_CHK_E;
            r_timeout <= 1'b1;
          end
        end
        ST_CHK_P: begin
          if (enemy_hp_in == '0) begin
            r_state     <= ST_WIN;
            r_game_over <= 1'b1;
          end else begin
            r_state       <= ST_ENEMY;
            r_phase_start <= 1'b1;
          end
        end
        ST_CHK_E: begin
          if (player_hp_in == '0) begin
            r_state     <= ST_LOSE;
            r_game_over <= 1'b1;
          end else begin
            r_state <= ST_MENU;
            if (r_round != ROUND_MAX)
              r_round <= r_round + 8'd1;
          end
        end
        ST_WIN, ST_LOSE: begin
          if (start_in) begin
            r_state     <= ST_IDLE;
            r_game_over <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_armed     <= 1'b0;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  assign state_out       = r_state;
  assign phase_start_out = r_phase_start;
  assign round_out       = r_round;
  assign timeout_out     = r_timeout;
  assign game_over_out   = r_game_over;

endmodule

// File: tb/tb_battle_sequencer.sv
// Bench for battle_sequencer: directed scenarios with literal expectations
// plus a randomized run checked against a rule-level model of the game.
module tb_battle_sequencer;

  localparam int T   = 100;
  localparam int HPW = 11;

`ifdef BATTLE_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [3:0] S_IDLE   = 4'b1010;
  localparam logic [3:0] S_MENU   = 4'b0000;
  localparam logic [3:0] S_PLAYER = 4'b0001;
  localparam logic [3:0] S_ENEMY  = 4'b0010;
  localparam logic [3:0] S_CHK_P  = 4'b0011;
  localparam logic [3:0] S_CHK_E  = 4'b0110;
  localparam logic [3:0] S_WIN    = 4'b0100;
  localparam logic [3:0] S_LOSE   = 4'b0101;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_in;
  logic [1:0]     rotate_in;
  logic           pf, ef;
  logic [HPW-1:0] ehp, php;
  logic [3:0]     state_out;
  logic           phase_start_out;
  logic [7:0]     round_out;
  logic           timeout_out;
  logic           game_over_out;

  int n_chk  = 0;
  int n_fail = 0;

  battle_sequencer #(.TIMEOUT_CYCLES(T), .HP_W(HPW)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_in           (start_in),
    .rotate_in          (rotate_in),
    .player_finished_in (pf),
    .enemy_finished_in  (ef),
    .enemy_hp_in        (ehp),
    .player_hp_in       (php),
    .state_out          (state_out),
    .phase_start_out    (phase_start_out),
    .round_out          (round_out),
    .timeout_out        (timeout_out),
    .game_over_out      (game_over_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: UP then SWIPE from MENU, leaving rotate neutral.
  task automatic swipe();
    rotate_in = 2'b00; tick();
    rotate_in = 2'b01; tick();
    rotate_in = 2'b10;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_in = 1'b1; tick(); tick();
    n_chk++; if (state_out !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %b want %b", state_out, S_IDLE); end
    n_chk++; if (phase_start_out !== 1'b0) begin n_fail++; $display("FAIL reset_ps got %b want 0", phase_start_out); end
    n_chk++; if (round_out !== 8'd0) begin n_fail++; $display("FAIL reset_round got %0d want 0", round_out); end
    n_chk++; if (timeout_out !== 1'b0) begin n_fail++; $display("FAIL reset_to got %b want 0", timeout_out); end
    n_chk++; if (game_over_out !== 1'b0) begin n_fail++; $display("FAIL reset_go got %b want 0", game_over_out); end
    rst = 1'b0; start_in = 1'b0; tick();
    n_chk++; if (state_out !== S_IDLE) begin n_fail++; $display("FAIL idle_hold got %b want %b", state_out, S_IDLE); end
  endtask

  task automatic test_start();
    start_in = 1'b1; tick(); start_in = 1'b0;
    n_chk++; if (state_out !== S_MENU) begin n_fail++; $display("FAIL start_state got %b want %b", state_out, S_MENU); end
    n_chk++; if (round_out !== 8'd0) begin n_fail++; $display("FAIL start_round got %0d want 0", round_out); end
  endtask

  task automatic test_menu_swipe();
    rotate_in = 2'b01; repeat (3) tick();
    n_chk++; if (state_out !== S_MENU) begin n_fail++; $display("FAIL unarmed_swipe got %b want %b", state_out, S_MENU); end
    rotate_in = 2'b00; tick();
    n_chk++; if (state_out !== S_MENU) begin n_fail++; $display("FAIL arm_only got %b want %b", state_out, S_MENU); end
    rotate_in = 2'b01; tick();
    n_chk++; if (state_out !== S_PLAYER) begin n_fail++; $display("FAIL swipe_state got %b want %b", state_out, S_PLAYER); end
    n_chk++; if (phase_start_out !== 1'b1) begin n_fail++; $display("FAIL swipe_ps got %b want 1", phase_start_out); end
    rotate_in = 2'b10; tick();
    n_chk++; if (phase_start_out !== 1'b0) begin n_fail++; $display("FAIL ps_pulse_width got %b want 0", phase_start_out); end
    n_chk++; if (state_out !== S_PLAYER) begin n_fail++; $display("FAIL player_hold got %b want %b", state_out, S_PLAYER); end
  endtask

  task automatic test_round();
    ehp = 11'd50; pf = 1'b1; tick();
    n_chk++; if (state_out !== S_CHK_P) begin n_fail++; $display("FAIL chkp_state got %b want %b", state_out, S_CHK_P); end
    pf = 1'b0; tick();
    n_chk++; if (state_out !== S_ENEMY) begin n_fail++; $display("FAIL enemy_state got %b want %b", state_out, S_ENEMY); end
    n_chk++; if (phase_start_out !== 1'b1) begin n_fail++; $display("FAIL enemy_ps got %b want 1", phase_start_out); end
    php = 11'd30; ef = 1'b1; tick();
    n_chk++; if (state_out !== S_CHK_E) begin n_fail++; $display("FAIL chke_state got %b want %b", state_out, S_CHK_E); end
    ef = 1'b0; tick();
    n_chk++; if (state_out !== S_MENU) begin n_fail++; $display("FAIL round_menu got %b want %b", state_out, S_MENU); end
    n_chk++; if (round_out !== 8'd1) begin n_fail++; $display("FAIL round_count got %0d want 1", round_out); end
  endtask

  task automatic test_win();
    swipe();
    ef = 1'b1; repeat (3) tick(); ef = 1'b0;
    n_chk++; if (state_out !== S_PLAYER) begin n_fail++; $display("FAIL foreign_finish got %b want %b", state_out, S_PLAYER); end
    ehp = 11'd0; pf = 1'b1; tick(); pf = 1'b0; tick();
    n_chk++; if (state_out !== S_WIN) begin n_fail++; $display("FAIL win_state got %b want %b", state_out, S_WIN); end
    n_chk++; if (game_over_out !== 1'b1) begin n_fail++; $display("FAIL win_go got %b want 1", game_over_out); end
    tick();
    n_chk++; if (state_out !== S_WIN) begin n_fail++; $display("FAIL win_hold got %b want %b", state_out, S_WIN); end
    start_in = 1'b1; tick(); start_in = 1'b0;
    n_chk++; if (state_out !== S_IDLE) begin n_fail++; $display("FAIL win_restart got %b want %b", state_out, S_IDLE); end
    n_chk++; if (game_over_out !== 1'b0) begin n_fail++; $display("FAIL restart_go got %b want 0", game_over_out); end
  endtask

  task automatic test_lose();
    start_in = 1'b1; tick(); start_in = 1'b0;
    n_chk++; if (round_out !== 8'd0) begin n_fail++; $display("FAIL round_clear got %0d want 0", round_out); end
    swipe();
    ehp = 11'd50; pf = 1'b1; tick(); pf = 1'b0; tick();
    php = 11'd0; ef = 1'b1; tick(); ef = 1'b0;
    n_chk++; if (state_out !== S_CHK_E) begin n_fail++; $display("FAIL lose_chke got %b want %b", state_out, S_CHK_E); end
    tick();
    n_chk++; if (state_out !== S_LOSE) begin n_fail++; $display("FAIL lose_state got %b want %b", state_out, S_LOSE); end
    n_chk++; if (game_over_out !== 1'b1) begin n_fail++; $display("FAIL lose_go got %b want 1", game_over_out); end
    n_chk++; if (round_out !== 8'd0) begin n_fail++; $display("FAIL lose_round got %0d want 0", round_out); end
    start_in = 1'b1; tick(); start_in = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    bit bad;
    start_in = 1'b1; tick(); start_in = 1'b0;
    swipe();
    if (TO_EN) begin
      n = 0;
      while (state_out === S_PLAYER && n < 2 * T) begin tick(); n++; end
      n_chk++; if (n !== T) begin n_fail++; $display("FAIL timeout_latency got %0d want %0d", n, T); end
      n_chk++; if (state_out !== S_CHK_P) begin n_fail++; $display("FAIL timeout_state got %b want %b", state_out, S_CHK_P); end
      n_chk++; if (timeout_out !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse got %b want 1", timeout_out); end
      ehp = 11'd50; tick();
      n_chk++; if (timeout_out !== 1'b0) begin n_fail++; $display("FAIL timeout_width got %b want 0", timeout_out); end
      n_chk++; if (state_out !== S_ENEMY) begin n_fail++; $display("FAIL after_timeout got %b want %b", state_out, S_ENEMY); end
      repeat (T - 1) tick();
      n_chk++; if (state_out !== S_ENEMY) begin n_fail++; $display("FAIL enemy_pre_expiry got %b want %b", state_out, S_ENEMY); end
      php = 11'd30; ef = 1'b1; tick(); ef = 1'b0;
      n_chk++; if (state_out !== S_CHK_E) begin n_fail++; $display("FAIL finish_at_expiry got %b want %b", state_out, S_CHK_E); end
      n_chk++; if (timeout_out !== 1'b0) begin n_fail++; $display("FAIL finish_beats_timeout got %b want 0", timeout_out); end
      tick();
    end else begin
      bad = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        tick();
        if (state_out !== S_PLAYER || timeout_out !== 1'b0) bad = 1'b1;
      end
      n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL no_watchdog_wait got %b want 0 (state %b)", bad, state_out); end
      ehp = 11'd50; pf = 1'b1; tick(); pf = 1'b0; tick();
      php = 11'd30; ef = 1'b1; tick(); ef = 1'b0; tick();
    end
  endtask

  task automatic test_reset_mid();
    swipe();
    ehp = 11'd50; pf = 1'b1; tick(); pf = 1'b0; tick();
    n_chk++; if (state_out !== S_ENEMY) begin n_fail++; $display("FAIL reach_enemy got %b want %b", state_out, S_ENEMY); end
    rst = 1'b1; start_in = 1'b1; ef = 1'b1; tick();
    rst = 1'b0; start_in = 1'b0; ef = 1'b0;
    n_chk++; if (state_out !== S_IDLE) begin n_fail++; $display("FAIL rst_mid_enemy got %b want %b", state_out, S_IDLE); end
    n_chk++; if (round_out !== 8'd0) begin n_fail++; $display("FAIL rst_mid_round got %0d want 0", round_out); end
  endtask

  task automatic test_round_sat();
    start_in = 1'b1; tick(); start_in = 1'b0;
    ehp = 11'd50; php = 11'd30;
    for (int r = 0; r < 260; r++) begin
      swipe();
      pf = 1'b1; tick(); pf = 1'b0; tick();
      ef = 1'b1; tick(); ef = 1'b0; tick();
    end
    n_chk++; if (round_out !== 8'd255) begin n_fail++; $display("FAIL round_saturate got %0d want 255", round_out); end
    n_chk++; if (state_out !== S_MENU) begin n_fail++; $display("FAIL sat_state got %b want %b", state_out, S_MENU); end
  endtask

  // Randomized run against a rule-level model of the game.
  task automatic test_random();
    logic [3:0] m_state;
    int         m_round, m_age, prints;
    bit         m_armed, e_ps, e_to, e_go, quiet;
    rst = 1'b1; tick(); rst = 1'b0;
    m_state = S_IDLE; m_round = 0; m_age = 0; m_armed = 0; prints = 0; quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) quiet = $urandom_range(0, 2) == 0;
      rst       = $urandom_range(0, 299) == 0;
      start_in  = $urandom_range(0, 3) == 0;
      rotate_in = 2'($urandom_range(0, 3));
      pf        = !quiet && ($urandom_range(0, 15) == 0);
      ef        = !quiet && ($urandom_range(0, 15) == 0);
      ehp       = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      php       = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      e_ps = 0; e_to = 0;
      if (rst) begin
        m_state = S_IDLE; m_round = 0; m_armed = 0; m_age = 0;
      end else if (m_state == S_IDLE) begin
        if (start_in) begin m_state = S_MENU; m_round = 0; end
      end else if (m_state == S_MENU) begin
        if (rotate_in == 2'b01 && m_armed) begin m_state = S_PLAYER; m_armed = 0; e_ps = 1; m_age = 0; end
        else if (rotate_in == 2'b00) m_armed = 1;
      end else if (m_state == S_PLAYER || m_state == S_ENEMY) begin
        if ((m_state == S_PLAYER) ? pf : ef)
          m_state = (m_state == S_PLAYER) ? S_CHK_P : S_CHK_E;
        else if (TO_EN && m_age == T - 1) begin
          m_state = (m_state == S_PLAYER) ? S_CHK_P : S_CHK_E; e_to = 1;
        end else m_age++;
      end else if (m_state == S_CHK_P) begin
        if (ehp == 0) m_state = S_WIN;
        else begin m_state = S_ENEMY; e_ps = 1; m_age = 0; end
      end else if (m_state == S_CHK_E) begin
        if (php == 0) m_state = S_LOSE;
        else begin m_state = S_MENU; m_round = (m_round < 255) ? m_round + 1 : 255; end
      end else if (start_in) begin
        m_state = S_IDLE;
      end
      e_go = (m_state == S_WIN) || (m_state == S_LOSE);
      tick();
      n_chk++; if (state_out !== m_state) begin n_fail++; if (prints++ < 20) $display("FAIL rnd_state cyc %0d got %b want %b", c, state_out, m_state); end
      n_chk++; if (round_out !== 8'(m_round)) begin n_fail++; if (prints++ < 20) $display("FAIL rnd_round cyc %0d got %0d want %0d", c, round_out, m_round); end
      n_chk++; if (phase_start_out !== e_ps) begin n_fail++; if (prints++ < 20) $display("FAIL rnd_ps cyc %0d got %b want %b", c, phase_start_out, e_ps); end
      n_chk++; if (timeout_out !== e_to) begin n_fail++; if (prints++ < 20) $display("FAIL rnd_to cyc %0d got %b want %b", c, timeout_out, e_to); end
      n_chk++; if (game_over_out !== e_go) begin n_fail++; if (prints++ < 20) $display("FAIL rnd_go cyc %0d got %b want %b", c, game_over_out, e_go); end
    end
    rst = 1'b0; start_in = 1'b0; pf = 1'b0; ef = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_in = 1'b0; rotate_in = 2'b10; pf = 1'b0; ef = 1'b0;
    ehp = 11'd100; php = 11'd100;
    test_reset();
    test_start();
    test_menu_swipe();
    test_round();
    test_win();
    test_lose();
    test_timeout();
    test_reset_mid();
    test_round_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/battle_sequencer.md
# battle_sequencer

Top-level turn controller for the battle screen. Drives the 4-bit `state_out` code consumed by the phase modules (player attack, enemy attack), and advances the game only when the active phase returns its `finished` handshake. Samples health from the health-bar blocks to decide win/lose, and counts rounds. Sits between the input decoder (`rotate_in`) and every phase/sprite module keyed on `state_in`.

## Interface
- `TIMEOUT_CYCLES`, default 650_000_000: per-phase watchdog limit (10 s at 65 MHz).
- `HP_W`, default 11: health input width.
- `clk` in 1: pixel clock.
- `rst` in 1: reset, synchronous, active-high.
- `start_in` in 1: start/restart request, level-sampled.
- `rotate_in` in 2: controller orientation; 2'b00 up, 2'b01 swipe.
- `player_finished_in` in 1: held high by the player phase until `state_out` leaves 4'b0001.
- `enemy_finished_in` in 1: held high by the enemy phase until `state_out` leaves 4'b0010.
- `enemy_hp_in` in HP_W: remaining enemy health.
- `player_hp_in` in HP_W: remaining player health.
- `state_out` out 4: current game state code.
- `phase_start_out` out 1: one-cycle pulse on entry to 4'b0001 or 4'b0010.
- `round_out` out 8: completed rounds, saturating.
- `timeout_out` out 1: one-cycle pulse when the watchdog forces a phase exit.
- `game_over_out` out 1: high in WIN or LOSE.

## Operation
- States and codes: IDLE 4'b1010, MENU 4'b0000, PLAYER 4'b0001, ENEMY 4'b0010, CHK_P 4'b0011 (after player), CHK_E 4'b0110 (after enemy), WIN 4'b0100, LOSE 4'b0101.
- IDLE -> MENU when `start_in`=1.
- MENU -> PLAYER through a swipe gesture:
  - `rotate_in`=2'b00 sets `armed`.
  - `rotate_in`=2'b01 while `armed` fires the transition.
  - `armed` clears on every MENU exit.
  - 2'b01 without prior arming is ignored.
- PLAYER -> CHK_P on `player_finished_in`=1 or watchdog expiry. ENEMY -> CHK_E on `enemy_finished_in`=1 or watchdog expiry.
- A finished input belonging to the other phase is ignored in every state.
- CHK_P (one cycle): `enemy_hp_in`==0 -> WIN, else -> ENEMY.
- CHK_E (one cycle): `player_hp_in`==0 -> LOSE, else -> MENU, with `round_out`+1 (saturates at 255).
- WIN/LOSE -> IDLE when `start_in`=1. `round_out` clears on IDLE -> MENU.
- The CHK states guarantee at least one cycle of a non-phase code between phases, so edge-detecting responders see every entry.

## Timing
- Reset values:
  - `state_out`=4'b1010
  - `phase_start_out`=0
  - `round_out`=0
  - `timeout_out`=0
  - `game_over_out`=0
  - `armed`=0
  - watchdog=0
- All outputs are registered. `state_out` changes on the clock edge after the cycle in which the qualifying input is sampled high (1-cycle latency).
- `phase_start_out` is high in the first cycle that `state_out` shows the new phase code.
- The watchdog clears on phase entry and increments each cycle in PLAYER/ENEMY.
  - When the count reaches TIMEOUT_CYCLES-1 without finished, the state advances and `timeout_out` pulses in the same edge.
  - If finished arrives in the same cycle as expiry, finished wins and there is no timeout pulse.
- HP is sampled only in the CHK cycle. HP changes during a phase have no effect.
- `rst` overrides all inputs, including `start_in` in the same cycle. Reset mid-phase returns to IDLE; responders see the code change and drop finished.
- `game_over_out` is combinationally equivalent to (state==WIN or LOSE) but registered alongside `state_out`.

## Configuration
- `BATTLE_SEQ_TIMEOUT_EN` defined: watchdog present as described.
- Not defined:
  - No watchdog counter.
  - Phases wait indefinitely for finished.
  - `timeout_out` tied 0.
  - `TIMEOUT_CYCLES` unused.

## Structure
- Package `battle_pkg`: state code localparams/enum (the eight codes above) and the `rotate_in` encodings, shared with the phase modules.
- Sub-module `phase_watchdog` (TIMEOUT_CYCLES param; `clear`, `enable` in; `expired` out), instantiated only under `BATTLE_SEQ_TIMEOUT_EN`.

## Test plan
- Reset, then `start_in` pulse -> `state_out` 1010 -> 0000 one cycle after `start_in`; `round_out`=0.
- In MENU, `rotate_in` 01 only -> stays 0000. Then 00, 01 -> 0001 with `phase_start_out` pulse in that cycle.
- PLAYER with `player_finished_in` held high and `enemy_hp_in`=50 -> sequence 0011 (1 cycle), 0010, `phase_start_out` pulse. Then `enemy_finished_in` with `player_hp_in`=30 -> 0110, 0000, `round_out`=1.
- PLAYER finish with `enemy_hp_in`=0 -> 0011, 0100, `game_over_out`=1. `start_in` -> 1010.
- ENEMY finish with `player_hp_in`=0 -> 0110, 0101, `game_over_out`=1. `enemy_finished_in` asserted in PLAYER -> ignored.
- Timeout (macro defined, TIMEOUT_CYCLES=100): PLAYER with no finished -> exit to 0011 exactly 100 cycles after entry, `timeout_out` 1-cycle pulse. Finished on cycle 100 -> no pulse. Macro undefined -> remains 0001 past 1000 cycles. `rst` mid-ENEMY -> 1010 next edge.
